// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter sharing one SPI bus among NREQ requesters; runs one
// full-duplex MSB-first transfer per grant in the requester's own CPOL/CPHA mode.
module spi_master_arbiter #(
  parameter int DWIDTH   = 8,
  parameter int NREQ     = 4,
  parameter int HALF_DIV = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_cpol,
  input  logic [NREQ-1:0]          req_cpha,
  input  logic [NREQ*DWIDTH-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DWIDTH-1:0]        rdata,
  output logic                     busy,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic [NREQ-1:0]          cs
);
  localparam int IW = $clog2(NREQ);
  localparam int EW = $clog2(2*DWIDTH);
  localparam int CW = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam logic [CW-1:0]   DIV_LAST  = CW'(HALF_DIV-1);
  localparam logic [EW-1:0]   EDGE_LAST = EW'(2*DWIDTH-1);
  localparam logic [IW-1:0]   IDX_LAST  = IW'(NREQ-1);
  localparam logic [NREQ-1:0] ONE       = NREQ'(1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, idx_q, idx_d, pick, cand;
  logic              found;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic [DWIDTH-1:0] tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d, wsel;
  logic [CW-1:0]     div_q, div_d;
  logic [EW-1:0]     edge_q, edge_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
  logic              div_end, fire, sample, drive;

  // First requester at or above the pointer, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    cand  = '0;
    wsel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = IW'((int'(ptr_q) + i) % NREQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    for (int k = 0; k < NREQ; k++)
      if (pick == IW'(k)) wsel = req_wdata[k*DWIDTH +: DWIDTH];
  end

  assign div_end = (div_q == DIV_LAST);
  assign fire    = div_end && (state_q == SETUP || state_q == SHIFT);
  // Even edges lead; CPHA picks whether leading or trailing edges sample.
  assign sample  = fire && (edge_q[0] == cpha_q);
  assign drive   = fire && (edge_q[0] != cpha_q) && (edge_q != EDGE_LAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cpol_d  = cpol_q;
    cpha_d  = cpha_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    edge_d  = edge_q;
    done_d  = 1'b0;
    div_d   = div_end ? '0 : div_q + 1'b1;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (found) begin
          state_d = SETUP;
          idx_d   = pick;
          ptr_d   = (pick == IDX_LAST) ? '0 : pick + 1'b1;
          cpol_d  = req_cpol[pick];
          cpha_d  = req_cpha[pick];
          sclk_d  = req_cpol[pick];
          edge_d  = '0;
          rx_d    = '0;
          // CPHA=0 presents the MSB before the first edge.
          if (req_cpha[pick]) begin
            tx_d = wsel;
          end else begin
            tx_d   = wsel << 1;
            mosi_d = wsel[DWIDTH-1];
          end
        end
      end
      SETUP: if (fire) state_d = SHIFT;
      SHIFT: if (fire && edge_q == EDGE_LAST) state_d = HOLD;
      HOLD: begin
        if (div_end) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rdata_d = rx_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fire) begin
      sclk_d = ~sclk_q;
      edge_d = edge_q + 1'b1;
    end
    if (sample) rx_d = {rx_q[DWIDTH-2:0], miso};
    if (drive) begin
      mosi_d = tx_q[DWIDTH-1];
      tx_d   = tx_q << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      div_q   <= '0;
      edge_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      div_q   <= div_d;
      edge_q  <= edge_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign cs    = busy ? (ONE << idx_q) : '0;
  assign gnt   = cs;
  assign done  = done_q ? (ONE << idx_q) : '0;
  assign rdata = rdata_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin scheduler plus SPI master shift engine that shares one SPI bus among NREQ requesters. Each requester supplies its own SPI mode (CPOL/CPHA) and one DWIDTH-bit transmit word. The block grants one requester at a time, runs one full-duplex MSB-first transfer on that requester's active-high chip select, and returns the received word. It sits between on-chip clients and the `spi_slave_bfm`-compatible SPI pins.

## Interface
- DWIDTH, 8, bits per transfer
- NREQ, 4, number of requesters (≥2)
- HALF_DIV, 2, clk cycles per SCLK half period (≥1)

- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req  in  NREQ  level request per requester
- req_cpol  in  NREQ  CPOL per requester
- req_cpha  in  NREQ  CPHA per requester
- req_wdata  in  NREQ*DWIDTH  tx word; requester k at bits [k*DWIDTH +: DWIDTH]
- gnt  out  NREQ  one-hot grant, held for the whole transfer
- done  out  NREQ  one-cycle completion pulse to the granted requester
- rdata  out  DWIDTH  received word, valid in the done cycle, held until the next done
- busy  out  1  high when state != IDLE
- sclk  out  1  SPI clock
- mosi  out  1  master out
- miso  in  1  master in
- cs  out  NREQ  chip selects, active-high, at most one high

## Operation
- States: IDLE, SETUP, SHIFT, HOLD.
- IDLE:
  - If any req bit is set, pick the first set bit searching from the round-robin pointer upward, with wrap.
  - Latch index, cpol, cpha and wdata into the shift register. Set pointer = index+1 mod NREQ. Go to SETUP.
  - With no req, stay in IDLE; sclk holds its last level.
- SETUP:
  - Lasts HALF_DIV cycles. cs[idx]=1, gnt[idx]=1, sclk=cpol.
  - If cpha=0, mosi = MSB from the first SETUP cycle.
  - At the end of SETUP, edge 0 fires and the state goes to SHIFT.
- SHIFT:
  - Edge counter runs 0..2*DWIDTH-1, one edge every HALF_DIV cycles. Even index = leading edge, odd index = trailing edge.
  - cpha=0: sample miso on leading edges; drive the next mosi bit on trailing edges, except the last one.
  - cpha=1: drive mosi on leading edges (edge 0 drives the MSB); sample on trailing edges.
  - Sample semantics: miso is shifted into the rx register LSB at the same clk edge at which the sclk register toggles.
  - After edge 2*DWIDTH-1, sclk = cpol; go to HOLD.
- HOLD:
  - Lasts HALF_DIV cycles; mosi holds.
  - On exit: cs=0, gnt=0, done[idx]=1, rdata = rx register; go to IDLE.
- req is sampled only in IDLE. Deasserting req mid-transfer does not abort; done still pulses. Changes to wdata or mode mid-transfer are ignored.
- busy = (state != IDLE).

## Timing
- Reset values: cs=0, gnt=0, done=0, rdata=0, busy=0, sclk=0, mosi=0. State = IDLE, round-robin pointer = 0.
- Latency: request seen in IDLE cycle T → cs/gnt high at T+1.
- cs is high for exactly HALF_DIV*(2*DWIDTH+1) cycles. Example: 34 cycles for DWIDTH=8, HALF_DIV=2.
- done pulses in the first IDLE cycle after HOLD, the same cycle cs falls.
- Back-to-back: arbitration runs in the done cycle, so cs is low for exactly 1 cycle between transfers.
- sclk makes exactly 2*DWIDTH transitions per transfer. sclk is at cpol whenever cs rises or falls.
- A mode change between transfers: sclk moves to the new cpol in the first SETUP cycle, while cs is already high. A slave must not treat this as an edge; HALF_DIV of setup precedes edge 0.
- Reset mid-transfer takes effect at the next clk edge:
  - all outputs return to reset values;
  - no done pulse; rdata is cleared;
  - the round-robin pointer returns to 0.
- Simultaneous requests: strict round-robin from the pointer. No requester waits more than NREQ-1 transfers.

## Test plan
- Single transfer, mode 0: req[1]=1, wdata[1]=0xA5, BFM slave sends 0x3C (DWIDTH=8, NREQ=4, HALF_DIV=2). Expect:
  - cs[1] high exactly 34 cycles with 16 sclk edges;
  - slave received_data=0xA5;
  - done[1] single pulse with rdata=0x3C.
- Modes 1, 2, 3 on requester 0, wdata 0x5A. Expect:
  - sclk idles at the matching cpol when cs rises and falls;
  - slave receives 0x5A in each mode;
  - rdata equals the slave's send_data in each mode.
- req=4'b1111 held for 5 transfers. Expect:
  - grants in order 0,1,2,3,0;
  - cs low exactly 1 cycle between transfers;
  - each done matches its gnt.
- Fairness: req[3] is granted; during that transfer req[0] and req[2] rise. Expect the next grant to 0, then 2.
- Reset at SHIFT edge 7. Expect:
  - next cycle cs=0, sclk=0, busy=0, with no done;
  - a following req[2] is granted with the pointer at 0 and completes normally.
- req[1] dropped 5 cycles into a transfer. Expect the transfer to complete, with done[1] pulsing and rdata valid.
